// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single BRAM controller port.
// Optional stall timeout is enabled with the MEM_ARB_TIMEOUT_EN macro.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Handshake: a master holds mX_valid with stable fields until mX_ready
  // pulses; mX_ready is s_ready passed straight through (or a timeout pulse).
  // State encoding doubles as the one-hot grant output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   is_gnt;
  logic   own_valid;
  logic   to_hit;

  assign is_gnt    = (state_q != IDLE);
  assign own_valid = (state_q == GNT1) ? m1_valid : m0_valid;
  assign grant     = state_q;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign to_hit      = is_gnt && !s_ready && (cnt_q == 16'(TIMEOUT - 1));
  assign timeout_err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (!is_gnt)
      cnt_d = 16'd0;
    else if (!s_ready)
      cnt_d = cnt_q + 16'd1;
    if (to_hit)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  localparam logic [15:0] unused_timeout = 16'(TIMEOUT);
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    s_wstrb  = 4'd0;
    m0_ready = 1'b0;
    m0_rdata = 32'd0;
    m1_ready = 1'b0;
    m1_rdata = 32'd0;
    case (state_q)
      GNT0: begin
        s_valid  = m0_valid && !to_hit;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready || to_hit;
        m0_rdata = to_hit ? 32'hDEADBEEF : s_rdata;
      end
      GNT1: begin
        s_valid  = m1_valid && !to_hit;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready || to_hit;
        m1_rdata = to_hit ? 32'hDEADBEEF : s_rdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie, last-served loses.
        if (m0_valid && m1_valid)
          state_d = last_q ? GNT0 : GNT1;
        else if (m0_valid)
          state_d = GNT0;
        else if (m1_valid)
          state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (s_ready || to_hit) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
        end else if (!own_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed checks of mem_bus_arbiter against a transaction-level
// reference model; define MEM_ARB_TIMEOUT_EN to exercise the timeout feature.
module tb_mem_bus_arbiter;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state: owner 0 = nobody, 1 = master 0, 2 = master 1.
  int owner, last_served, stall;
  bit err_flag;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs with the model, then advance the model over the edge.
  task automatic model_step();
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    logic [3:0]  e_wstrb;
    logic        e_sv, e_r0, e_r1, own_v;
    bit          hit;
    own_v   = (owner == 1) ? m0_valid : (owner == 2) ? m1_valid : 1'b0;
    hit     = TMO_EN && owner != 0 && !s_ready && stall == int'(TMO) - 1;
    e_sv    = (owner != 0) && own_v && !hit;
    e_addr  = (owner == 1) ? m0_addr  : (owner == 2) ? m1_addr  : 32'd0;
    e_wdata = (owner == 1) ? m0_wdata : (owner == 2) ? m1_wdata : 32'd0;
    e_wstrb = (owner == 1) ? m0_wstrb : (owner == 2) ? m1_wstrb : 4'd0;
    e_r0    = (owner == 1) && (s_ready || hit);
    e_r1    = (owner == 2) && (s_ready || hit);
    e_rd0   = (owner != 1) ? 32'd0 : hit ? 32'hDEADBEEF : s_rdata;
    e_rd1   = (owner != 2) ? 32'd0 : hit ? 32'hDEADBEEF : s_rdata;

    check("grant",       32'(grant),       32'(owner));
    check("s_valid",     32'(s_valid),     32'(e_sv));
    check("s_addr",      s_addr,           e_addr);
    check("s_wdata",     s_wdata,          e_wdata);
    check("s_wstrb",     32'(s_wstrb),     32'(e_wstrb));
    check("m0_ready",    32'(m0_ready),    32'(e_r0));
    check("m0_rdata",    m0_rdata,         e_rd0);
    check("m1_ready",    32'(m1_ready),    32'(e_r1));
    check("m1_rdata",    m1_rdata,         e_rd1);
    check("timeout_err", 32'(timeout_err), 32'(err_flag));

    if (!reset_n) begin
      owner = 0; last_served = 1; stall = 0; err_flag = 0;
    end else if (owner == 0) begin
      stall = 0;
      if (m0_valid && m1_valid) owner = (last_served == 0) ? 2 : 1;
      else if (m0_valid)        owner = 1;
      else if (m1_valid)        owner = 2;
    end else if (s_ready || hit) begin
      last_served = owner - 1;
      if (!s_ready) err_flag = 1;
      owner = 0;
    end else if (!own_v) begin
      owner = 0;
    end else begin
      stall++;
    end
  endtask

  task automatic do_cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    run(2);
    reset_n = 1;
  endtask

  initial begin
    logic [1:0] gq[$];
    idle_inputs();
    reset_n = 0;
    @(posedge clk);
    #1;
    owner = 0; last_served = 1; stall = 0; err_flag = 0;
    apply_reset();

    // Single m0 write: forwarded one cycle after request, ready with s_ready.
    m0_valid = 1; m0_addr = 32'h8; m0_wdata = 32'hAA; m0_wstrb = 4'hF;
    do_cycle();
    check("wr_sval", 32'(s_valid), 32'd1);
    check("wr_addr", s_addr, 32'h8);
    s_ready = 1; s_rdata = 32'h1234;
    #1;
    check("wr_ready", 32'(m0_ready), 32'd1);
    do_cycle();
    idle_inputs();
    run(2);

    // Tie from reset: m0 first, an idle gap, then m1.
    apply_reset();
    m0_valid = 1; m1_valid = 1; m1_addr = 32'h40; s_ready = 1;
    do_cycle();
    check("tie_g0", 32'(grant), 32'd1);
    do_cycle();
    check("tie_idle_g", 32'(grant), 32'd0);
    check("tie_idle_sv", 32'(s_valid), 32'd0);
    do_cycle();
    check("tie_g1", 32'(grant), 32'd2);

    // Continuous requests alternate owners.
    idle_inputs();
    run(2);
    apply_reset();
    m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'h77;
    for (int i = 0; i < 8; i++) begin
      if (grant != 2'b00) gq.push_back(grant);
      do_cycle();
    end
    check("alt_n", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check("alt_g", 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // m1 read of 0x1C returning 0x55.
    idle_inputs();
    run(2);
    m1_valid = 1; m1_addr = 32'h1C; m1_wstrb = 4'h0;
    do_cycle();
    s_ready = 1; s_rdata = 32'h55;
    #1;
    check("rd_m1_rdata", m1_rdata, 32'h55);
    check("rd_m0_rdata", m0_rdata, 32'h0);
    do_cycle();
    idle_inputs();
    run(2);

    // Slave that never answers.
    apply_reset();
    m0_valid = 1;
    run(TMO);
`ifdef MEM_ARB_TIMEOUT_EN
    check("tmo_ready", 32'(m0_ready), 32'd1);
    check("tmo_rdata", m0_rdata, 32'hDEADBEEF);
    do_cycle();
    m0_valid = 0;
    run(3);
    check("tmo_err", 32'(timeout_err), 32'd1);
`else
    run(20);
    check("hold_g", 32'(grant), 32'd1);
    check("hold_err", 32'(timeout_err), 32'd0);
`endif
    idle_inputs();
    run(2);

    // Reset in the middle of a GNT1 grant.
    apply_reset();
    m1_valid = 1;
    run(2);
    check("rst_pre_g", 32'(grant), 32'd2);
    reset_n = 0;
    do_cycle();
    check("rst_g", 32'(grant), 32'd0);
    check("rst_sv", 32'(s_valid), 32'd0);
    reset_n = 1; m0_valid = 1;
    do_cycle();
    check("rst_tie", 32'(grant), 32'd1);
    idle_inputs();
    run(2);

    // Random traffic, including protocol violations and resets.
    for (int i = 0; i < 3000; i++) begin
      m0_valid = ($urandom_range(0, 3) != 0);
      m1_valid = ($urandom_range(0, 3) != 0);
      m0_addr  = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom_range(0, 15));
      m1_addr  = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom_range(0, 15));
      s_ready  = ($urandom_range(0, 2) == 0);
      s_rdata  = $urandom;
      reset_n  = ($urandom_range(0, 99) != 0);
      do_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
